// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 CPU bus front end.
package mmc1_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, EMIT} state_t;

  localparam logic [1:0] SEL_CTRL = 2'd0;
  localparam logic [1:0] SEL_CHR0 = 2'd1;
  localparam logic [1:0] SEL_CHR1 = 2'd2;
  localparam logic [1:0] SEL_PRG  = 2'd3;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_M2_FILT     = 2;
  localparam int DEF_MAX_HIGH    = 64;

  // Bit order matches the raw bus vector built in the top level.
  typedef struct packed {
    logic       romsel_n;
    logic       rw_n;
    logic [1:0] sel;
    logic       d7;
    logic       d0;
  } cpu_cap_t;

endpackage

// File: rtl/mmc1_sync_filt.sv
// One-bit CPU input synchronizer, followed either by an M2_FILT-sample deglitcher
// or by a plain M2_FILT-flop delay so bypassed bits stay aligned with filtered M2.
module mmc1_sync_filt
  import mmc1_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int M2_FILT     = DEF_M2_FILT,
  parameter bit FILT_EN     = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '0;
    else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  generate
    if (FILT_EN) begin : g_filt
      localparam int CW = (M2_FILT > 1) ? $clog2(M2_FILT) : 1;
      logic [CW-1:0] cnt_q;
      logic          filt_q;

      // Output flips only after M2_FILT consecutive samples disagree with it.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(M2_FILT-1)) begin
          filt_q <= ~filt_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      assign dout = filt_q;
    end else begin : g_dly
      logic [M2_FILT-1:0] dly_q;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) dly_q <= '0;
        else begin
          dly_q[0] <= sync_q[SYNC_STAGES-1];
          for (int i = 1; i < M2_FILT; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign dout = dly_q[M2_FILT-1];
    end
  endgenerate

endmodule

// File: rtl/mmc1_cpu_bus_capture.sv
// MMC1 CPU bus capture: turns completed $8000-$FFFF CPU writes into one-clock strobes.
// Define MMC1_CONSEC_WR_FILTER_EN to drop the second of two back-to-back ROM writes.
module mmc1_cpu_bus_capture
  import mmc1_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int M2_FILT     = DEF_M2_FILT,
  parameter int MAX_HIGH    = DEF_MAX_HIGH
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CPU_M2,
  input  logic       nCPU_ROMSEL,
  input  logic       nCPU_RW,
  input  logic       CPU_A14,
  input  logic       CPU_A13,
  input  logic       CPU_D7,
  input  logic       CPU_D0,
  output logic       WR_STB,
  output logic [1:0] WR_SEL,
  output logic       WR_D7,
  output logic       WR_D0,
  output logic       CYC_ABORT
);

  localparam int HCW  = $clog2(MAX_HIGH + 1);
  localparam int WARM = SYNC_STAGES + M2_FILT;
  localparam int WCW  = $clog2(WARM + 1);

  logic [5:0] raw_vec, syn_vec;
  cpu_cap_t   syn_cap, cap_q;
  logic       m2_f, m2_q;
  state_t     state, nxt;
  logic [HCW-1:0] hi_cnt;
  logic [WCW-1:0] warm_q;
  logic       armed;
  logic       go_emit, go_abort, cand, accept;

  assign raw_vec = {nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0};
  assign syn_cap = cpu_cap_t'(syn_vec);

  mmc1_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .M2_FILT(M2_FILT), .FILT_EN(1'b1)) u_m2sync (
    .CLK(CLK), .RST(RST), .din(CPU_M2), .dout(m2_f)
  );

  mmc1_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .M2_FILT(M2_FILT), .FILT_EN(1'b0)) u_dsync [5:0] (
    .CLK(CLK), .RST(RST), .din(raw_vec), .dout(syn_vec)
  );

  // Cleared synchronizers fake an M2 rise when M2 is already high at reset release;
  // only arm rise detection once filtered M2 has settled and been seen low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      warm_q <= '0;
      armed  <= 1'b0;
    end else begin
      if (warm_q != WCW'(WARM)) warm_q <= warm_q + 1'b1;
      else if (!m2_f)           armed  <= 1'b1;
    end
  end

  assign cand = !cap_q.romsel_n && !cap_q.rw_n;

`ifdef MMC1_CONSEC_WR_FILTER_EN
  logic prev_wr;
  assign accept = cand && !prev_wr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           prev_wr <= 1'b0;
    else if (go_emit)  prev_wr <= cand;
    else if (go_abort) prev_wr <= 1'b0;
  end
`else
  assign accept = cand;
`endif

  always_comb begin
    nxt      = state;
    go_emit  = 1'b0;
    go_abort = 1'b0;
    unique case (state)
      IDLE: if (armed && m2_f && !m2_q) nxt = HIGH;
      HIGH: begin
        if (!m2_f) begin
          nxt     = EMIT;
          go_emit = 1'b1;
        end else if (hi_cnt == HCW'(MAX_HIGH)) begin
          nxt      = IDLE;
          go_abort = 1'b1;
        end
      end
      EMIT:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered on the HIGH->EMIT edge, so the strobe occupies the EMIT clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      m2_q      <= 1'b0;
      hi_cnt    <= '0;
      cap_q     <= '1;
      WR_STB    <= 1'b0;
      CYC_ABORT <= 1'b0;
      WR_SEL    <= SEL_CTRL;
      WR_D7     <= 1'b0;
      WR_D0     <= 1'b0;
    end else begin
      state     <= nxt;
      m2_q      <= m2_f;
      if (state != HIGH)                                hi_cnt <= '0;
      else if (hi_cnt != HCW'(MAX_HIGH))                hi_cnt <= hi_cnt + 1'b1;
      if (m2_f) cap_q <= syn_cap;
      WR_STB    <= go_emit && accept;
      CYC_ABORT <= go_abort;
      if (go_emit && accept) begin
        WR_SEL <= cap_q.sel;
        WR_D7  <= cap_q.d7;
        WR_D0  <= cap_q.d0;
      end
    end
  end

endmodule

// File: tb/tb_mmc1_cpu_bus_capture.sv
// Directed bench for mmc1_cpu_bus_capture with an event-queue model of expected strobes.
module tb_mmc1_cpu_bus_capture;
  import mmc1_pkg::*;

  localparam int S = 2, F = 2, MAXH = 64;
`ifdef MMC1_CONSEC_WR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic CLK = 1'b0, RST = 1'b1;
  logic CPU_M2 = 1'b0, nCPU_ROMSEL = 1'b1, nCPU_RW = 1'b1;
  logic CPU_A14 = 1'b0, CPU_A13 = 1'b0, CPU_D7 = 1'b0, CPU_D0 = 1'b0;
  logic WR_STB, WR_D7, WR_D0, CYC_ABORT;
  logic [1:0] WR_SEL;

  mmc1_cpu_bus_capture #(.SYNC_STAGES(S), .M2_FILT(F), .MAX_HIGH(MAXH)) dut (
    .CLK(CLK), .RST(RST), .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
    .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D7(CPU_D7), .CPU_D0(CPU_D0),
    .WR_STB(WR_STB), .WR_SEL(WR_SEL), .WR_D7(WR_D7), .WR_D0(WR_D0), .CYC_ABORT(CYC_ABORT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    bit         ab;
    logic [1:0] sel;
    bit         d7;
    bit         d0;
  } ev_t;

  ev_t evq[$];
  int  cyc = 0;
  int  n_chk = 0, n_err = 0;
  int  n_stb = 0, n_ab = 0, last_stb_cyc = -1, last_ab_cyc = -1;
  int  last_r1 = 0, last_f1 = 0;
  bit  prev_wr_m = 1'b0;
  logic [1:0] m_sel = 2'd0;
  bit  m_d7 = 1'b0, m_d0 = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the model's expectation.
  always @(negedge CLK) begin : cmp
    bit es, ea;
    ev_t ev;
    es = 1'b0;
    ea = 1'b0;
    if (RST) begin
      m_sel = 2'd0; m_d7 = 1'b0; m_d0 = 1'b0;
      evq.delete();
    end
    if (evq.size() > 0 && evq[0].cyc < cyc) begin
      chk("event_overdue", cyc, evq[0].cyc);
      void'(evq.pop_front());
    end
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      ev = evq.pop_front();
      if (ev.ab) ea = 1'b1;
      else begin
        es = 1'b1; m_sel = ev.sel; m_d7 = ev.d7; m_d0 = ev.d0;
      end
    end
    chk("wr_stb", WR_STB, es);
    chk("cyc_abort", CYC_ABORT, ea);
    chk("wr_sel", WR_SEL, m_sel);
    chk("wr_d7", WR_D7, m_d7);
    chk("wr_d0", WR_D0, m_d0);
    if (WR_STB) begin n_stb++; last_stb_cyc = cyc; end
    if (CYC_ABORT) begin n_ab++; last_ab_cyc = cyc; end
  end

  // One M2 period: hi_len clocks high (optional 1-clock glitch low, optional reset), 8 low.
  task automatic bus_cycle(input bit rs_n, input bit rw_n, input logic [1:0] sel,
                           input bit d7, input bit d0, input int hi_len,
                           input int glitch_at, input int rst_at);
    int r1, f1;
    bit rst_hit, abort, cand;
    @(negedge CLK);
    nCPU_ROMSEL = rs_n; nCPU_RW = rw_n; {CPU_A14, CPU_A13} = sel;
    CPU_D7 = d7; CPU_D0 = d0; CPU_M2 = 1'b1;
    r1 = cyc + 1;
    rst_hit = 1'b0;
    abort = (hi_len >= MAXH + 2) && (rst_at < 0);
    if (abort) evq.push_back('{cyc: r1 + S + F + MAXH + 1, ab: 1'b1, sel: 2'd0, d7: 1'b0, d0: 1'b0});
    for (int i = 0; i < hi_len; i++) begin
      CPU_M2 = (i == glitch_at) ? 1'b0 : 1'b1;
      if (i == rst_at) begin
        #2 RST = 1'b1;
        #1;
        chk("rst_async_stb", WR_STB, 0);
        chk("rst_async_sel", WR_SEL, 0);
        chk("rst_async_d0", WR_D0, 0);
        chk("rst_async_d7", WR_D7, 0);
        rst_hit = 1'b1;
        prev_wr_m = 1'b0;
      end
      if (rst_at >= 0 && i == rst_at + 2) #2 RST = 1'b0;
      @(negedge CLK);
    end
    f1 = cyc + 1;
    CPU_M2 = 1'b0;
    if (abort) prev_wr_m = 1'b0;
    else if (!rst_hit) begin
      cand = !rs_n && !rw_n;
      if (cand && !(FILT && prev_wr_m))
        evq.push_back('{cyc: f1 + S + F, ab: 1'b0, sel: sel, d7: d7, d0: d0});
      prev_wr_m = cand;
    end
    last_r1 = r1;
    last_f1 = f1;
    repeat (8) @(negedge CLK);
    nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
  endtask

  task automatic rom_read();
    bus_cycle(1'b0, 1'b1, SEL_CTRL, 1'b0, 1'b0, 8, -1, -1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: timeout, errors so far %0d", n_err);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s0, a0;
    repeat (4) @(negedge CLK);
    chk("reset_stb", WR_STB, 0);
    chk("reset_abort", CYC_ABORT, 0);
    chk("reset_sel", WR_SEL, 0);
    #2 RST = 1'b0;
    repeat (10) @(negedge CLK);

    // $8000 write, D0=1
    s0 = n_stb;
    bus_cycle(1'b0, 1'b0, SEL_CTRL, 1'b0, 1'b1, 12, -1, -1);
    chk("t1_count", n_stb - s0, 1);
    chk("t1_latency", last_stb_cyc - last_f1, 4);
    chk("t1_sel", WR_SEL, 0);
    chk("t1_d0", WR_D0, 1);
    chk("t1_d7", WR_D7, 0);
    rom_read();

    // $E000 write D7=1, then read $E000: outputs must hold
    s0 = n_stb;
    bus_cycle(1'b0, 1'b0, SEL_PRG, 1'b1, 1'b0, 12, -1, -1);
    bus_cycle(1'b0, 1'b1, SEL_PRG, 1'b0, 1'b1, 12, -1, -1);
    chk("t2_count", n_stb - s0, 1);
    chk("t2_sel", WR_SEL, 3);
    chk("t2_d7", WR_D7, 1);
    chk("t2_d0", WR_D0, 0);

    // back-to-back $A000 writes
    s0 = n_stb;
    bus_cycle(1'b0, 1'b0, SEL_CHR0, 1'b0, 1'b1, 12, -1, -1);
    bus_cycle(1'b0, 1'b0, SEL_CHR0, 1'b0, 1'b0, 12, -1, -1);
    chk("t3_count", n_stb - s0, FILT ? 1 : 2);
    chk("t3_d0", WR_D0, FILT ? 1 : 0);
    chk("t3_sel", WR_SEL, 1);
    rom_read();

    // $C000 write with a 1-clock M2 low glitch mid-phase
    s0 = n_stb;
    bus_cycle(1'b0, 1'b0, SEL_CHR1, 1'b0, 1'b1, 12, 5, -1);
    chk("t4_count", n_stb - s0, 1);
    chk("t4_latency", last_stb_cyc - last_f1, 4);
    chk("t4_sel", WR_SEL, 2);

    // M2 stuck high 70 clocks: abort, then a normal write still strobes
    s0 = n_stb; a0 = n_ab;
    bus_cycle(1'b0, 1'b0, SEL_CTRL, 1'b0, 1'b0, 70, -1, -1);
    chk("t5_abort_count", n_ab - a0, 1);
    chk("t5_stb_count", n_stb - s0, 0);
    chk("t5_abort_time", last_ab_cyc - last_r1, 69);
    s0 = n_stb;
    bus_cycle(1'b0, 1'b0, SEL_CTRL, 1'b0, 1'b1, 12, -1, -1);
    chk("t5b_count", n_stb - s0, 1);
    chk("t5b_d0", WR_D0, 1);

    // reset during the high phase of a write
    s0 = n_stb;
    bus_cycle(1'b0, 1'b0, SEL_PRG, 1'b1, 1'b1, 14, -1, 5);
    chk("t6_count", n_stb - s0, 0);
    chk("t6_sel", WR_SEL, 0);
    chk("t6_d7", WR_D7, 0);
    s0 = n_stb;
    bus_cycle(1'b0, 1'b0, SEL_CHR0, 1'b0, 1'b1, 12, -1, -1);
    chk("t6b_count", n_stb - s0, 1);
    chk("t6b_sel", WR_SEL, 1);
    chk("t6b_d0", WR_D0, 1);

    repeat (4) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
